// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the lock_supervisor slice.
//   - 3-bit state codes as localparams plus an enum built from them
//   - sample_good(): the signed discriminator-vs-threshold qualifier
package lock_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SCAN    = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_LOCKED  = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;
    localparam logic [2:0] ST_FAIL    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_SCAN    = ST_SCAN,
        S_SETTLE  = ST_SETTLE,
        S_LOCKED  = ST_LOCKED,
        S_RECOVER = ST_RECOVER,
        S_FAIL    = ST_FAIL
    } lock_state_e;

    // Strictly greater: a sample sitting exactly on the threshold is bad.
    function automatic logic sample_good(input logic signed [15:0] disc,
                                         input logic signed [15:0] thr);
        return disc > thr;
    endfunction

endpackage

// File: rtl/lock_supervisor_if.sv
// lock_supervisor_if: host config, discriminator sample stream, PI rail
// flags and the supervisor's control/status outputs for one lock channel.
//   master: host / scan-gen / PI-core side (drives config and samples)
//   slave : lock_supervisor side
interface lock_supervisor_if;
    logic               enable;
    logic               update;
    logic signed [15:0] discriminator;
    logic signed [15:0] threshold;
    logic [15:0]        settle_samples;
    logic [15:0]        lost_samples;
    logic [31:0]        timeout;
    logic [7:0]         max_retries;
    logic               pi_overflow;
    logic               pi_underflow;

    logic               scan_enable;
    logic               pi_enable;
    logic               pi_sclr;
    logic               locked;
    logic               fail;
    logic [2:0]         state;
    logic [15:0]        relock_count;

    modport master (
        output enable, update, discriminator, threshold, settle_samples,
               lost_samples, timeout, max_retries, pi_overflow, pi_underflow,
        input  scan_enable, pi_enable, pi_sclr, locked, fail, state,
               relock_count
    );

    modport slave (
        input  enable, update, discriminator, threshold, settle_samples,
               lost_samples, timeout, max_retries, pi_overflow, pi_underflow,
        output scan_enable, pi_enable, pi_sclr, locked, fail, state,
               relock_count
    );
endinterface

// File: rtl/run_counter.sv
// run_counter: 16-bit saturating event counter with terminal-count compare.
//   clr      - zero the count (wins over inc)
//   inc      - count one event this cycle
//   terminal - count value that ends the run
//   hit      - this cycle's increment brings the count to (or past) terminal
module run_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    input  logic [15:0] terminal,
    output logic        hit
);
    logic [15:0] count_q;
    logic [16:0] count_nx;

    assign count_nx = {1'b0, count_q} + 17'd1;
    // >= so a terminal lowered below the running count ends the run on the
    // next counted event instead of waiting for a wrap.
    assign hit = inc && !clr && (count_nx >= {1'b0, terminal});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= 16'd0;
        else if (clr)
            count_q <= 16'd0;
        else if (inc && count_q != 16'hFFFF)
            count_q <= count_nx[15:0];
    end
endmodule

// File: rtl/lock_supervisor.sv
// lock_supervisor: acquire / settle / monitor sequencer for one PI lock
// channel. Scans until a good discriminator sample, lets the loop settle for
// settle_samples good samples, then watches for loss of lock (consecutive bad
// samples or a PI rail flag) and relocks with a bounded retry count.
//   clk, rst_n - clock, async active-low reset
//   bus        - lock_supervisor_if.slave: config, samples, rail flags in;
//                scan_enable, pi_enable, pi_sclr, locked, fail, state,
//                relock_count out (all registered)
module lock_supervisor
    import lock_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    lock_supervisor_if.slave  bus
);
    lock_state_e state_q, state_d;
    logic [31:0] timer_q;
    logic [7:0]  retry_q, retry_inc;
    logic [15:0] relock_q;
    logic        sclr_d, attempt_fail;
    logic        good, bad, timed_out, retries_spent;
    logic        settle_hit, lost_hit;
    logic [15:0] lost_term;

    logic scan_en_q, pi_en_q, sclr_q, locked_q, fail_q;

    assign good = bus.update &&  sample_good(bus.discriminator, bus.threshold);
    assign bad  = bus.update && !sample_good(bus.discriminator, bus.threshold);

    assign timed_out     = (bus.timeout != 32'd0) && (timer_q == bus.timeout);
    assign retry_inc     = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
    assign retries_spent = (bus.max_retries != 8'd0) && (retry_inc == bus.max_retries);
    assign lost_term     = (bus.lost_samples == 16'd0) ? 16'd1 : bus.lost_samples;

    // Good samples seen in SETTLE.
    run_counter u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_q != S_SETTLE),
        .inc      (state_q == S_SETTLE && good),
        .terminal (bus.settle_samples),
        .hit      (settle_hit)
    );

    // Consecutive bad samples in LOCKED; a good sample restarts the run.
    run_counter u_lost (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_q != S_LOCKED || good),
        .inc      (state_q == S_LOCKED && bad),
        .terminal (lost_term),
        .hit      (lost_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        sclr_d       = 1'b0;
        attempt_fail = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SCAN;
                    sclr_d  = 1'b1;
                end
                S_SCAN: begin
                    // A good sample on the timeout cycle still counts as acquired.
                    if (good)           state_d = S_SETTLE;
                    else if (timed_out) attempt_fail = 1'b1;
                end
                S_SETTLE: begin
                    if (bus.settle_samples == 16'd0) state_d = S_LOCKED;
                    else if (bad)                    attempt_fail = 1'b1;
                    else if (settle_hit)             state_d = S_LOCKED;
                end
                S_LOCKED: begin
                    if (bus.pi_overflow || bus.pi_underflow || lost_hit) begin
                        state_d = S_RECOVER;
                        sclr_d  = 1'b1;
                    end
                end
                S_RECOVER: state_d = S_SCAN;
                S_FAIL:    state_d = S_FAIL;
                default:   state_d = S_IDLE;
            endcase
            if (attempt_fail) begin
                if (retries_spent) begin
                    state_d = S_FAIL;
                end else begin
                    state_d = S_SCAN;
                    sclr_d  = 1'b1;
                end
            end
        end
    end

    // Per-attempt SCAN timer: reads 1 in the first cycle of each attempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer_q <= 32'd0;
        else if (state_d != S_SCAN)
            timer_q <= 32'd0;
        else if (state_q != S_SCAN || attempt_fail)
            timer_q <= 32'd1;
        else if (timer_q != 32'hFFFF_FFFF)
            timer_q <= timer_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retry_q <= 8'd0;
        else if (state_d == S_IDLE || state_d == S_LOCKED)
            retry_q <= 8'd0;
        else if (attempt_fail)
            retry_q <= retry_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            relock_q <= 16'd0;
        else if (state_d == S_IDLE)
            relock_q <= 16'd0;
        else if (state_q == S_LOCKED && state_d == S_RECOVER && relock_q != 16'hFFFF)
            relock_q <= relock_q + 16'd1;
    end

    // Moore outputs registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_en_q <= 1'b0;
            pi_en_q   <= 1'b0;
            sclr_q    <= 1'b0;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            scan_en_q <= (state_d == S_SCAN);
            pi_en_q   <= (state_d == S_SETTLE) || (state_d == S_LOCKED);
            sclr_q    <= sclr_d;
            locked_q  <= (state_d == S_LOCKED);
            fail_q    <= (state_d == S_FAIL);
        end
    end

    assign bus.scan_enable  = scan_en_q;
    assign bus.pi_enable    = pi_en_q;
    assign bus.pi_sclr      = sclr_q;
    assign bus.locked       = locked_q;
    assign bus.fail         = fail_q;
    assign bus.state        = state_q;
    assign bus.relock_count = relock_q;

endmodule
